regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read decode-stage register file.
- Configurable data width, depth, read-port count and write-port count.
- Adds a hardware clear sequencer after reset, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- Sits in the decode stage: read ports feed operand muxes, write ports come from writeback, scoreboard set comes from issue.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, ≥2; AW = clog2(DEPTH) is a derived localparam.
- NR, 2, number of read ports.
- NW, 1, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see stored value only.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_i  in  NR*AW  read addresses; port k at [k*AW +: AW].
- rd_data_o  out  NR*XLEN  read data, combinational; port k at [k*XLEN +: XLEN].
- rd_busy_o  out  NR  scoreboard busy bit for each read address.
- wr_en_i  in  NW  write enables.
- wr_addr_i  in  NW*AW  write addresses.
- wr_data_i  in  NW*XLEN  write data.
- set_en_i  in  1  mark register busy (issue of a producer).
- set_addr_i  in  AW  register to mark busy.
- ready_o  out  1  high once the clear sweep is complete; file usable.

Behaviour:
- Reset (rst_n=0, async): FSM goes to CLEAR, sweep index = 0, all busy bits = 0, ready_o = 0. Array contents are not reset directly.
- FSM states:
  - CLEAR: each cycle writes 0 to entry[index], then index++. After entry DEPTH-1 is written, go to READY.
  - ready_o = 1 from the first cycle in READY.
  - The sweep takes exactly DEPTH cycles after rst_n rises.
  - READY: normal operation; stays there until the next reset.
- Reset mid-sweep: the sweep restarts from index 0.
- During CLEAR:
  - wr_en_i and set_en_i are ignored.
  - rd_data_o = 0 and rd_busy_o = 0.
- Register 0 is hardwired:
  - Reads of address 0 always return 0, with busy = 0.
  - Writes to and sets of address 0 are ignored.
- Writes: on the clock edge, for each port with wr_en_i=1 and a nonzero address, entry <= data.
  - Same address on several ports: the highest-indexed port wins.
- Reads (combinational):
  - BYPASS=1: if any enabled, nonzero write port matches the read address this cycle, return that port's data (highest-indexed match wins); otherwise return the stored value.
  - BYPASS=0: return the stored value; new data is visible the cycle after the write.
- Scoreboard:
  - A write with wr_en_i=1 to address a clears busy[a] on the edge.
  - set_en_i sets busy[set_addr_i] on the edge.
  - Set and clear of the same address in the same cycle: set wins, busy stays 1 (new producer supersedes).
  - rd_busy_o[k] = busy[rd_addr k], registered value only; no bypass of set or clear.
- Read latency is 0 cycles. Write latency to storage is 1 edge.
- Widths: addresses are AW bits, so there is no out-of-range address. Writes carry no sign or width conversion.

Test Plan:
- Release rst_n, DEPTH=32 → ready_o=0 for 32 cycles, 1 on cycle 32; every read returns 0x0 and busy=0; a write attempted at cycle 5 has no effect afterwards.
- READY: write x5=0xDEADBEEF, BYPASS=1, read port0=x5 in the same cycle → 0xDEADBEEF combinationally; BYPASS=0 build → old value 0, then 0xDEADBEEF the next cycle.
- NW=2: both ports write x7 (port0=0x1111, port1=0x2222) → x7 reads 0x2222; write x0=0xFFFFFFFF → x0 still reads 0.
- set x3 → rd_busy=1 next cycle; write x3=0x55 → busy=0 next cycle; set and write x3 in the same cycle → busy stays 1, data=0x55.
- Assert rst_n=0 at sweep index 10 for 1 cycle, release → ready_o rises exactly 32 cycles after release; busy bits all 0.
- NR=4 random traffic (1000 cycles) vs. reference model: read data and busy match every cycle; reads of x0 are always 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read, write-back and scoreboard-set ports plus ready.
// master = decode/writeback side, slave = register file.
interface regfile_mp_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NR   = 2,
  parameter int unsigned NW   = 1
);

  logic [NR*AW-1:0]   rd_addr_i;
  logic [NR*XLEN-1:0] rd_data_o;
  logic [NR-1:0]      rd_busy_o;
  logic [NW-1:0]      wr_en_i;
  logic [NW*AW-1:0]   wr_addr_i;
  logic [NW*XLEN-1:0] wr_data_i;
  logic               set_en_i;
  logic [AW-1:0]      set_addr_i;
  logic               ready_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, set_en_i, set_addr_i,
    input  rd_data_o, rd_busy_o, ready_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, set_en_i, set_addr_i,
    output rd_data_o, rd_busy_o, ready_o
  );

endinterface

// File: rtl/regfile_mp.sv
// Multi-port decode-stage register file with post-reset clear sweep,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NR     = 2,
  parameter int unsigned NW     = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic         clk_i,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready;
  logic            clr_we;

  logic [XLEN-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;

  logic [AW-1:0]   rd_addr [NR];
  logic [AW-1:0]   wr_addr [NW];
  logic [XLEN-1:0] wr_data [NW];
  logic [NR*XLEN-1:0] rd_data_c;
  logic [NR-1:0]      rd_busy_c;

  // Unpack flat bus vectors into per-port views
  for (genvar k = 0; k < NR; k++) begin : g_rd_unpack
    assign rd_addr[k] = bus.rd_addr_i[k*AW +: AW];
  end

  for (genvar w = 0; w < NW; w++) begin : g_wr_unpack
    assign wr_addr[w] = bus.wr_addr_i[w*AW +: AW];
    assign wr_data[w] = bus.wr_data_i[w*XLEN +: XLEN];
  end

  // FSM state register and sweep index
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: sweep every entry once, then stay ready until reset
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    ready  = 1'b0;
    clr_we = 1'b0;
    case (state_q)
      S_CLEAR: clr_we = 1'b1;
      S_READY: ready  = 1'b1;
      default: clr_we = 1'b1;
    endcase
  end

  // Storage: sweep writes zero; otherwise highest-indexed write port wins
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[idx_q] <= '0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (bus.wr_en_i[w] && (wr_addr[w] != '0)) begin
          mem[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  // Scoreboard next value: writes retire a producer, a new issue overrides
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NW; w++) begin
      if (bus.wr_en_i[w]) begin
        busy_d[wr_addr[w]] = 1'b0;
      end
    end
    if (bus.set_en_i) begin
      busy_d[bus.set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else if (ready) begin
      busy_q <= busy_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int k = 0; k < NR; k++) begin
      logic [XLEN-1:0] v;
      v = mem[rd_addr[k]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NW; w++) begin
          if (bus.wr_en_i[w] && (wr_addr[w] != '0) && (wr_addr[w] == rd_addr[k])) begin
            v = wr_data[w];
          end
        end
      end
      if (!ready || (rd_addr[k] == '0)) begin
        v = '0;
      end
      rd_data_c[k*XLEN +: XLEN] = v;
      rd_busy_c[k] = ready && (rd_addr[k] != '0) && busy_q[rd_addr[k]];
    end
  end

  assign bus.rd_data_o = rd_data_c;
  assign bus.rd_busy_o = rd_busy_c;
  assign bus.ready_o   = ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a bypass and a non-bypass regfile_mp share one stimulus
// stream and are compared every cycle against a behavioural register-file model.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 4;
  localparam int unsigned NW    = 2;

  logic clk_i = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [AW-1:0]   rd_addr [NR];
  logic [NW-1:0]   wr_en;
  logic [AW-1:0]   wr_addr [NW];
  logic [XLEN-1:0] wr_data [NW];
  logic            set_en;
  logic [AW-1:0]   set_addr;

  regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NR(NR), .NW(NW)) bus_a ();
  regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NR(NR), .NW(NW)) bus_b ();

  for (genvar k = 0; k < NR; k++) begin : g_rd
    assign bus_a.rd_addr_i[k*AW +: AW] = rd_addr[k];
    assign bus_b.rd_addr_i[k*AW +: AW] = rd_addr[k];
  end
  for (genvar w = 0; w < NW; w++) begin : g_wr
    assign bus_a.wr_addr_i[w*AW +: AW]     = wr_addr[w];
    assign bus_b.wr_addr_i[w*AW +: AW]     = wr_addr[w];
    assign bus_a.wr_data_i[w*XLEN +: XLEN] = wr_data[w];
    assign bus_b.wr_data_i[w*XLEN +: XLEN] = wr_data[w];
  end
  assign bus_a.wr_en_i    = wr_en;
  assign bus_b.wr_en_i    = wr_en;
  assign bus_a.set_en_i   = set_en;
  assign bus_b.set_en_i   = set_en;
  assign bus_a.set_addr_i = set_addr;
  assign bus_b.set_addr_i = set_addr;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .BYPASS(1)) u_byp (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .BYPASS(0)) u_nobyp (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles since release, zeroed file, busy set
  int unsigned     m_cnt;
  logic [XLEN-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_busy = '0;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    end else if (m_cnt < DEPTH) begin
      m_cnt = m_cnt + 1;
    end else begin
      for (int w = 0; w < int'(NW); w++) begin
        if (wr_en[w] && wr_addr[w] != '0) begin
          m_mem[wr_addr[w]] = wr_data[w];
          m_busy[wr_addr[w]] = 1'b0;
        end
      end
      if (set_en && set_addr != '0) m_busy[set_addr] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (m_cnt < DEPTH || a == '0) return '0;
    v = m_mem[a];
    if (byp) begin
      for (int w = 0; w < int'(NW); w++) begin
        if (wr_en[w] && wr_addr[w] == a) v = wr_data[w];
      end
    end
    return v;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    return (m_cnt >= DEPTH) && (a != '0) && m_busy[a];
  endfunction

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("ready_byp",   64'(bus_a.ready_o), 64'(m_cnt >= DEPTH));
      chk("ready_nobyp", 64'(bus_b.ready_o), 64'(m_cnt >= DEPTH));
      for (int k = 0; k < int'(NR); k++) begin
        chk($sformatf("rd_data_byp[%0d]", k),   64'(bus_a.rd_data_o[k*XLEN +: XLEN]), 64'(exp_rd(rd_addr[k], 1'b1)));
        chk($sformatf("rd_data_nobyp[%0d]", k), 64'(bus_b.rd_data_o[k*XLEN +: XLEN]), 64'(exp_rd(rd_addr[k], 1'b0)));
        chk($sformatf("rd_busy_byp[%0d]", k),   64'(bus_a.rd_busy_o[k]), 64'(exp_busy(rd_addr[k])));
        chk($sformatf("rd_busy_nobyp[%0d]", k), 64'(bus_b.rd_busy_o[k]), 64'(exp_busy(rd_addr[k])));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    set_en = 1'b0;
    for (int w = 0; w < int'(NW); w++) begin
      wr_addr[w] = '0;
      wr_data[w] = '0;
    end
    set_addr = '0;
  endtask

  // Count the sweep after release; pokes a write/set at cycle 5
  task automatic sweep_and_check(input string tag);
    for (int c = 1; c <= int'(DEPTH); c++) begin
      tick();
      idle();
      if (c == 5) begin
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'h1234_5678;
        set_en = 1'b1; set_addr = 5'd5;
      end
      if (c == int'(DEPTH) - 1) chk({tag, "_ready_low_at_31"}, 64'(bus_a.ready_o), 64'd0);
      if (c == int'(DEPTH))     chk({tag, "_ready_high_at_32"}, 64'(bus_a.ready_o), 64'd1);
    end
  endtask

  initial begin
    idle();
    for (int k = 0; k < int'(NR); k++) rd_addr[k] = '0;
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    rd_addr[0] = 5'd3;
    tick(); tick();
    chk("rst_ready", 64'(bus_a.ready_o), 64'd0);
    chk("rst_busy",  64'(bus_a.rd_busy_o), 64'd0);

    rst_n = 1'b1;
    sweep_and_check("sweep");
    rd_addr[0] = 5'd5;
    #1;
    chk("clear_write_dropped", 64'(bus_a.rd_data_o[31:0]), 64'd0);
    chk("clear_set_dropped",   64'(bus_a.rd_busy_o[0]), 64'd0);

    // Same-cycle bypass vs. stored value
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
    #1;
    chk("x5_bypass_same",   64'(bus_a.rd_data_o[31:0]), 64'h0000_0000_DEAD_BEEF);
    chk("x5_nobypass_same", 64'(bus_b.rd_data_o[31:0]), 64'd0);
    tick(); idle(); #1;
    chk("x5_nobypass_next", 64'(bus_b.rd_data_o[31:0]), 64'h0000_0000_DEAD_BEEF);

    // Two ports to x7: port1 wins
    rd_addr[1] = 5'd7;
    wr_en = 2'b11; wr_addr[0] = 5'd7; wr_data[0] = 32'h1111; wr_addr[1] = 5'd7; wr_data[1] = 32'h2222;
    #1;
    chk("x7_bypass_port1_wins", 64'(bus_a.rd_data_o[63:32]), 64'h2222);
    tick(); idle(); #1;
    chk("x7_stored_port1_wins", 64'(bus_b.rd_data_o[63:32]), 64'h2222);

    // x0 hardwired
    rd_addr[2] = 5'd0;
    wr_en = 2'b10; wr_addr[1] = 5'd0; wr_data[1] = 32'hFFFF_FFFF;
    #1;
    chk("x0_bypass_zero", 64'(bus_a.rd_data_o[95:64]), 64'd0);
    tick(); idle(); #1;
    chk("x0_stored_zero", 64'(bus_b.rd_data_o[95:64]), 64'd0);

    // Scoreboard set / clear / set-wins
    rd_addr[3] = 5'd3;
    set_en = 1'b1; set_addr = 5'd3;
    #1;
    chk("x3_busy_not_bypassed", 64'(bus_a.rd_busy_o[3]), 64'd0);
    tick(); idle(); #1;
    chk("x3_busy_after_set", 64'(bus_a.rd_busy_o[3]), 64'd1);
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h55;
    tick(); idle(); #1;
    chk("x3_busy_after_write", 64'(bus_a.rd_busy_o[3]), 64'd0);
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h55;
    set_en = 1'b1; set_addr = 5'd3;
    tick(); idle(); #1;
    chk("x3_set_wins", 64'(bus_a.rd_busy_o[3]), 64'd1);
    chk("x3_data",     64'(bus_b.rd_data_o[127:96]), 64'h55);

    // Reset mid-sweep at index 10
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sweep_and_check("resweep");
    rd_addr[0] = 5'd5;
    #1;
    chk("resweep_x3_busy_clear", 64'(bus_a.rd_busy_o[3]), 64'd0);
    chk("resweep_x5_zero",       64'(bus_b.rd_data_o[31:0]), 64'd0);

    // Random traffic on a small address window to provoke hazards
    for (int n = 0; n < 1000; n++) begin
      tick();
      wr_en = NW'($urandom);
      for (int w = 0; w < int'(NW); w++) begin
        wr_addr[w] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        wr_data[w] = $urandom;
      end
      set_en   = ($urandom_range(0, 2) == 0);
      set_addr = AW'($urandom_range(0, 7));
      for (int k = 0; k < int'(NR); k++) begin
        case ($urandom_range(0, 3))
          0: rd_addr[k] = '0;
          1: rd_addr[k] = wr_addr[$urandom_range(0, NW - 1)];
          2: rd_addr[k] = AW'($urandom);
          default: rd_addr[k] = AW'($urandom_range(0, 7));
        endcase
      end
    end
    tick(); idle();
    tick();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
